// File: rtl/ad5328_rx_if.sv
// Purpose: groups the AD5328 serial pins, decoded-frame outputs and readback port.
// Latency: n/a (signal bundle only).
// Backpressure: none; the serial writer cannot be stalled.
interface ad5328_rx_if;
  logic        sync_n;
  logic        sclk;
  logic        din;
  logic        ldac_n;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic        frame_ctrl;
  logic        frame_err;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;

  // Writer / bench side: drives the serial lines and readback address
  modport master (
    output sync_n, sclk, din, ldac_n, rd_addr,
    input  frame_valid, frame_data, frame_ctrl, frame_err, rd_data
  );

  // Decoder side
  modport slave (
    input  sync_n, sclk, din, ldac_n, rd_addr,
    output frame_valid, frame_data, frame_ctrl, frame_err, rd_data
  );
endinterface

// File: rtl/ad5328_rx.sv
// Purpose: oversampling decoder for the AD5328 3-wire frame plus input/output DAC register model.
// Latency: frame_valid SYNC_STAGES+2 clk after the 16th pin-level sclk fall; rd_data 1 clk after rd_addr.
// Backpressure: none; every frame is reported as it arrives and registers update unconditionally.
module ad5328_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CH_NUM      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ad5328_rx_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;

  // Line order inside each sync stage: {ldac_n, din, sclk, sync_n}
  logic [3:0]  r_sync [SYNC_STAGES];
  logic [2:0]  r_hist;                 // {ldac_n, sclk, sync_n} one cycle older
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_shreg;
  logic [4:0]  r_cnt;
  logic [11:0] r_in_reg  [CH_NUM];
  logic [11:0] r_out_reg [CH_NUM];
  logic        r_frame_valid;
  logic [15:0] r_frame_data;
  logic        r_frame_ctrl;
  logic        r_frame_err;
  logic [11:0] r_rd_data;

  logic w_sync_s, w_sclk_s, w_din_s, w_ldac_s;
  logic w_sync_fall, w_sync_rise, w_sclk_fall, w_ldac_fall;
  logic w_shift_en, w_last_bit, w_done, w_err, w_wr;
  logic [2:0]  w_addr;
  logic [11:0] w_wdat;

  assign w_sync_s    = r_sync[SYNC_STAGES-1][0];
  assign w_sclk_s    = r_sync[SYNC_STAGES-1][1];
  assign w_din_s     = r_sync[SYNC_STAGES-1][2];
  assign w_ldac_s    = r_sync[SYNC_STAGES-1][3];
  assign w_sync_fall = r_hist[0] & ~w_sync_s;
  assign w_sync_rise = ~r_hist[0] & w_sync_s;
  assign w_sclk_fall = r_hist[1] & ~w_sclk_s;
  assign w_ldac_fall = r_hist[2] & ~w_ldac_s;

  // Synchronise the async lines; reset to 0 so a line held low across reset never looks like a fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= {bus.ldac_n, bus.din, bus.sclk, bus.sync_n};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= {w_ldac_s, w_sclk_s, w_sync_s};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; a sync rise that lands with the 16th sclk fall still completes the frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_sync_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (r_cnt == 5'd16)                    w_state_nxt = w_sync_s ? ST_IDLE : ST_HOLD;
        else if (w_sync_rise && !w_last_bit)   w_state_nxt = ST_IDLE;
      end
      ST_HOLD:  if (w_sync_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: shift strobe, frame completion and truncated-frame error
  always_comb begin
    w_shift_en = (r_state == ST_SHIFT) && w_sclk_fall && (r_cnt != 5'd16);
    w_last_bit = w_shift_en && (r_cnt == 5'd15);
    w_done     = (r_state == ST_SHIFT) && (r_cnt == 5'd16);
    w_err      = (r_state == ST_SHIFT) && (r_cnt != 5'd16) && w_sync_rise && !w_last_bit &&
                 ((r_cnt != 5'd0) || w_shift_en);
  end

  // Shift register and bit counter, cleared at each frame start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if ((r_state == ST_IDLE) && w_sync_fall) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_shift_en) begin
      r_shreg <= {r_shreg[14:0], w_din_s};
      r_cnt   <= r_cnt + 5'd1;
    end
  end

  assign w_wr   = w_done && !r_shreg[15];
  assign w_addr = r_shreg[14:12];
  assign w_wdat = r_shreg[11:0];

  // DAC registers: ldac fall copies all inputs; a data write goes through to the output while ldac is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_in_reg[i]  <= '0;
        r_out_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_ldac_fall) r_out_reg[i] <= r_in_reg[i];
        if (w_wr && (int'(w_addr) == i)) begin
          r_in_reg[i] <= w_wdat;
          if (!w_ldac_s) r_out_reg[i] <= w_wdat;
        end
      end
    end
  end

  // Frame report registers; frame_data holds the last good word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_frame_data  <= '0;
      r_frame_ctrl  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= w_done;
      r_frame_ctrl  <= w_done & r_shreg[15];
      r_frame_err   <= w_err;
      if (w_done) r_frame_data <= r_shreg;
    end
  end

  // Registered readback of the selected output register
  always_ff @(posedge clk) begin
    if (!rst_n)                         r_rd_data <= '0;
    else if (int'(bus.rd_addr) < CH_NUM) r_rd_data <= r_out_reg[bus.rd_addr];
    else                                r_rd_data <= '0;
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_data  = r_frame_data;
  assign bus.frame_ctrl  = r_frame_ctrl;
  assign bus.frame_err   = r_frame_err;
  assign bus.rd_data     = r_rd_data;

endmodule

// File: tb/tb_ad5328_rx.sv
// Purpose: self-checking bench for ad5328_rx (directed table, corner sequences, random vs model).
// Latency: n/a.
// Backpressure: n/a.
module tb_ad5328_rx;

  localparam int OP_NONE  = 0;
  localparam int OP_FRAME = 1;
  localparam int OP_PULSE = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ad5328_rx_if bus ();

  ad5328_rx #(.SYNC_STAGES(2), .CH_NUM(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          op;
    logic [15:0] word;
    int          nbits;
    int          extra;
    bit          ldac_low;
    logic [2:0]  rd_ch;
    logic [11:0] exp_rd;
    int          exp_valid;
    int          exp_err;
    logic [15:0] exp_data;
    logic        exp_ctrl;
  } vec_t;

  vec_t        tbl [9];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_valid = 0;
  int          n_err = 0;
  logic        mon_ctrl = 1'b0;
  logic [11:0] in_m  [8];
  logic [11:0] out_m [8];
  logic [15:0] cur_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  always @(negedge clk) begin
    if (bus.frame_valid) begin
      n_valid++;
      mon_ctrl = bus.frame_ctrl;
    end
    if (bus.frame_err) n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      in_m[i]  = '0;
      out_m[i] = '0;
    end
    cur_data = '0;
  endtask

  task automatic m_ldac_fall();
    for (int i = 0; i < 8; i++) out_m[i] = in_m[i];
  endtask

  task automatic bit_out(input logic b);
    bus.sclk = 1'b1;
    bus.din  = b;
    tick(3);
    bus.sclk = 1'b0;
    tick(3);
  endtask

  // One writer transaction; the model sees the write only for complete data words
  task automatic do_frame(input logic [15:0] w, input int nbits, input int extra, input bit ldac_low);
    if (ldac_low) begin
      bus.ldac_n = 1'b0;
      tick(4);
      m_ldac_fall();
    end
    bus.sync_n = 1'b0;
    tick(3);
    for (int i = 0; i < nbits; i++) bit_out(w[15-i]);
    for (int i = 0; i < extra; i++) bit_out(1'b0);
    bus.sync_n = 1'b1;
    tick(6);
    if (ldac_low) begin
      bus.ldac_n = 1'b1;
      tick(4);
    end
    if (nbits == 16) begin
      cur_data = w;
      if (!w[15]) begin
        in_m[w[14:12]] = w[11:0];
        if (ldac_low) out_m[w[14:12]] = w[11:0];
      end
    end
  endtask

  task automatic ldac_pulse();
    bus.ldac_n = 1'b0;
    tick(4);
    bus.ldac_n = 1'b1;
    tick(4);
    m_ldac_fall();
  endtask

  task automatic check_ch(input int ch);
    bus.rd_addr = ch[2:0];
    tick(2);
    chk($sformatf("rd_ch%0d", ch), {20'd0, bus.rd_data}, {20'd0, out_m[ch]});
  endtask

  initial begin
    int v0, e0, f, lat;
    logic [15:0] w;

    tbl[0] = '{OP_FRAME, 16'h3A5C, 16, 0, 1'b0, 3'd3, 12'h000, 1, 0, 16'h3A5C, 1'b0};
    tbl[1] = '{OP_PULSE, 16'h0000,  0, 0, 1'b0, 3'd3, 12'hA5C, 0, 0, 16'h3A5C, 1'b0};
    tbl[2] = '{OP_NONE,  16'h0000,  0, 0, 1'b0, 3'd2, 12'h000, 0, 0, 16'h3A5C, 1'b0};
    tbl[3] = '{OP_FRAME, 16'h7FFF, 16, 0, 1'b1, 3'd7, 12'hFFF, 1, 0, 16'h7FFF, 1'b0};
    tbl[4] = '{OP_FRAME, 16'h1234,  9, 0, 1'b0, 3'd7, 12'hFFF, 0, 1, 16'h7FFF, 1'b0};
    tbl[5] = '{OP_FRAME, 16'h1123, 16, 0, 1'b0, 3'd1, 12'h000, 1, 0, 16'h1123, 1'b0};
    tbl[6] = '{OP_PULSE, 16'h0000,  0, 0, 1'b0, 3'd1, 12'h123, 0, 0, 16'h1123, 1'b0};
    tbl[7] = '{OP_FRAME, 16'h8003, 16, 4, 1'b0, 3'd0, 12'h000, 1, 0, 16'h8003, 1'b1};
    tbl[8] = '{OP_NONE,  16'h0000,  0, 0, 1'b0, 3'd3, 12'hA5C, 0, 0, 16'h8003, 1'b0};

    bus.sync_n  = 1'b1;
    bus.sclk    = 1'b0;
    bus.din     = 1'b0;
    bus.ldac_n  = 1'b1;
    bus.rd_addr = 3'd0;
    rst_n       = 1'b0;
    m_reset();
    tick(4);
    rst_n = 1'b1;
    tick(2);
    chk("rst_valid", {31'd0, bus.frame_valid}, 0);
    chk("rst_data",  {16'd0, bus.frame_data},  0);
    chk("rst_ctrl",  {31'd0, bus.frame_ctrl},  0);
    chk("rst_err",   {31'd0, bus.frame_err},   0);
    chk("rst_rd",    {20'd0, bus.rd_data},     0);

    // Directed table
    for (int t = 0; t < 9; t++) begin
      v0 = n_valid;
      e0 = n_err;
      if (tbl[t].op == OP_FRAME)      do_frame(tbl[t].word, tbl[t].nbits, tbl[t].extra, tbl[t].ldac_low);
      else if (tbl[t].op == OP_PULSE) ldac_pulse();
      chk($sformatf("t%0d_valid", t), n_valid - v0, tbl[t].exp_valid);
      chk($sformatf("t%0d_err", t),   n_err - e0,   tbl[t].exp_err);
      chk($sformatf("t%0d_data", t),  {16'd0, bus.frame_data}, {16'd0, tbl[t].exp_data});
      if (tbl[t].exp_valid == 1) chk($sformatf("t%0d_ctrl", t), {31'd0, mon_ctrl}, {31'd0, tbl[t].exp_ctrl});
      bus.rd_addr = tbl[t].rd_ch;
      tick(2);
      chk($sformatf("t%0d_rd", t), {20'd0, bus.rd_data}, {20'd0, tbl[t].exp_rd});
    end
    for (int ch = 0; ch < 8; ch++) check_ch(ch);

    // Latency from pin-level 16th sclk fall, and transparent write seen on rd_data
    w = 16'h7ABC;
    bus.rd_addr = 3'd7;
    bus.ldac_n  = 1'b0;
    tick(4);
    m_ldac_fall();
    bus.sync_n = 1'b0;
    tick(3);
    for (int i = 0; i < 15; i++) bit_out(w[15-i]);
    bus.sclk = 1'b1;
    bus.din  = w[0];
    tick(3);
    bus.sclk = 1'b0;
    f = cyc;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        lat = cyc - f;
        break;
      end
    end
    chk("latency", lat, 4);
    tick(2);
    chk("lat_rd7", {20'd0, bus.rd_data}, 32'h0ABC);
    bus.sync_n = 1'b1;
    tick(6);
    bus.ldac_n = 1'b1;
    tick(4);
    in_m[7] = 12'hABC;
    out_m[7] = 12'hABC;
    cur_data = w;

    // sclk fall and sync rise together on bit 16: valid frame, then decoder must be idle again
    w = 16'h2468;
    v0 = n_valid;
    e0 = n_err;
    bus.sync_n = 1'b0;
    tick(3);
    for (int i = 0; i < 15; i++) bit_out(w[15-i]);
    bus.sclk = 1'b1;
    bus.din  = w[0];
    tick(3);
    bus.sclk   = 1'b0;
    bus.sync_n = 1'b1;
    tick(8);
    chk("sim_valid", n_valid - v0, 1);
    chk("sim_err",   n_err - e0,   0);
    chk("sim_data",  {16'd0, bus.frame_data}, 32'h2468);
    in_m[2] = 12'h468;
    cur_data = w;
    v0 = n_valid;
    do_frame(16'h2135, 16, 0, 1'b0);
    chk("after_sim_valid", n_valid - v0, 1);
    chk("after_sim_data",  {16'd0, bus.frame_data}, 32'h2135);

    // Reset in the middle of a frame
    bus.rd_addr = 3'd7;
    tick(2);
    bus.sync_n = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) bit_out(1'b1);
    rst_n = 1'b0;
    tick(3);
    chk("mid_rst_valid", {31'd0, bus.frame_valid}, 0);
    chk("mid_rst_data",  {16'd0, bus.frame_data},  0);
    chk("mid_rst_ctrl",  {31'd0, bus.frame_ctrl},  0);
    chk("mid_rst_err",   {31'd0, bus.frame_err},   0);
    chk("mid_rst_rd",    {20'd0, bus.rd_data},     0);
    m_reset();
    rst_n = 1'b1;
    tick(2);
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 8; i++) bit_out(1'b1);
    bus.sync_n = 1'b1;
    tick(6);
    chk("tail_valid", n_valid - v0, 0);
    chk("tail_err",   n_err - e0,   0);
    v0 = n_valid;
    do_frame(16'h0001, 16, 0, 1'b0);
    chk("post_rst_valid", n_valid - v0, 1);
    chk("post_rst_data",  {16'd0, bus.frame_data}, 32'h0001);
    ldac_pulse();
    for (int ch = 0; ch < 8; ch++) check_ch(ch);

    // Random transactions against the reference model
    for (int it = 0; it < 30; it++) begin
      int kind, nb;
      kind = $urandom_range(0, 3);
      v0 = n_valid;
      e0 = n_err;
      if (kind <= 1) begin
        w = 16'($urandom);
        do_frame(w, 16, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        chk($sformatf("r%0d_valid", it), n_valid - v0, 1);
        chk($sformatf("r%0d_err", it),   n_err - e0,   0);
        chk($sformatf("r%0d_ctrl", it),  {31'd0, mon_ctrl}, {31'd0, w[15]});
      end else if (kind == 2) begin
        nb = $urandom_range(1, 15);
        do_frame(16'($urandom), nb, 0, 1'b0);
        chk($sformatf("r%0d_valid", it), n_valid - v0, 0);
        chk($sformatf("r%0d_err", it),   n_err - e0,   1);
      end else begin
        ldac_pulse();
      end
      chk($sformatf("r%0d_data", it), {16'd0, bus.frame_data}, {16'd0, cur_data});
      check_ch($urandom_range(0, 7));
    end
    for (int ch = 0; ch < 8; ch++) check_ch(ch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
